serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and the default operand width.
package serial_subtractor_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int unsigned DefaultWidth = 8;

  // Controller states. IDLE accepts operands, SHIFT walks the bits LSB first,
  // DONE presents the result until the consumer takes it.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with bout set when the
// subtraction needs to borrow from the next bit up.
module serial_subtractor_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of the three inputs.
  assign d    = a ^ b ^ bin;
  // Borrow out when b exceeds a, or when they match and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Accepts an operand pair on a valid/ready
// handshake, produces one difference bit per clock LSB first, and presents
// (in_a - in_b) mod 2^WIDTH plus an underflow flag on a second valid/ready
// handshake. Only one operation is in flight at a time.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             busy
);

  // Counter only has to reach WIDTH-1; it is cleared on every acceptance.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Holds the first WIDTH-1 difference bits; the last bit comes straight
  // from the cell when the result is committed.
  logic [WIDTH-2:0] r_res;
  logic             r_bor;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_full;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;

  assign w_accept   = (r_state == StIdle) && in_valid;
  assign w_shift    = (r_state == StShift);
  assign w_last     = w_shift && (r_cnt == CntW'(WIDTH - 1));
  // New difference bit enters at the MSB, earlier bits move toward the LSB.
  assign w_res_full = {w_d, r_res};

  serial_subtractor_full_subtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bor),
    .d    (w_d),
    .bout (w_bout)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: accept in IDLE, count out WIDTH steps, wait for consumer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_state_next = StShift;
        end
      end
      StShift: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Serial datapath: load operands on acceptance, then one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bor    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_res <= '0;
      r_bor <= 1'b0;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res_full[WIDTH-1:1];
      r_bor <= w_bout;
      r_cnt <= r_cnt + CntW'(1);
      // Result registers only change here, so they hold through DONE and IDLE.
      if (w_last) begin
        r_diff   <= w_res_full;
        r_borrow <= w_bout;
      end
    end
  end

  assign in_ready   = (r_state == StIdle);
  assign out_valid  = (r_state == StDone);
  assign busy       = (r_state != StIdle);
  assign out_diff   = r_diff;
  assign out_borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases followed by
// randomized operand pairs with random handshake gaps, checked against plain
// modular arithmetic.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n_hs  = 0;
  int n_exp = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count every completed output handshake to catch lost or duplicated results.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) n_hs++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Wait for the result of an already accepted op, compare with a - b, and
  // complete the output handshake with out_ready held high.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] exp_d;
    logic         exp_b;
    int           lat = 0;
    exp_d = a - b;
    exp_b = (a < b);
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, W);
    check({tag, "_diff"}, {24'd0, out_diff}, {24'd0, exp_d});
    check({tag, "_borrow"}, {31'd0, out_borrow}, {31'd0, exp_b});
    out_ready = 1'b1;
    tick();
    n_exp++;
    check({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    out_ready = 1'b1;
    wait_ready(tag);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scribble the operand bus to show post-acceptance changes are ignored.
    in_a     = ~a;
    in_b     = ~b;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    finish_op(a, b, tag);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] exp_d;
    logic         exp_b;
    logic         seen;
    logic         first;
    logic         done;
    logic         hs;
    int           cyc;

    // Reset held for three edges while operands are offered.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_a     = 8'h12;
    in_b     = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_diff", {24'd0, out_diff}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
    end
    check("rst_borrow", {31'd0, out_borrow}, 32'd0);
    // First edge with rst_n high takes the waiting operands.
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rst_accept", {31'd0, busy}, 32'd1);
    finish_op(8'h12, 8'h02, "rst_op");

    // Basic and wrap-around cases.
    run_op(8'h5A, 8'h23, "basic");
    run_op(8'h00, 8'h01, "wrap0");
    run_op(8'h7F, 8'h80, "wrap1");
    run_op(8'hA5, 8'hA5, "equal");
    run_op(8'hFF, 8'h00, "ffmin0");

    // Backpressure: result held while out_ready is low; new offers ignored.
    out_ready = 1'b0;
    wait_ready("bp");
    in_a     = 8'h80;
    in_b     = 8'h7F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("bp_lat", cyc, W);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 8'h10;
      in_b     = 8'h01;
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_diff", {24'd0, out_diff}, 32'h01);
      check("bp_borrow", {31'd0, out_borrow}, 32'd0);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_exp++;
    check("bp_release", {31'd0, in_ready}, 32'd1);
    check("bp_vdrop", {31'd0, out_valid}, 32'd0);
    run_op(8'h10, 8'h01, "bp_next");

    // Reset on the fourth SHIFT step abandons the operation.
    wait_ready("mid");
    in_a     = 8'h33;
    in_b     = 8'h11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_ready", {31'd0, in_ready}, 32'd1);
    check("mid_diff", {24'd0, out_diff}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | (out_valid === 1'b1);
    end
    check("mid_novalid", {31'd0, seen}, 32'd0);
    run_op(8'h40, 8'h41, "mid_next");

    // Randomized operands with random input gaps, junk offers while busy and
    // random output backpressure.
    for (int k = 0; k < 200; k++) begin
      in_valid = 1'b0;
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        in_a = W'($urandom);
        tick();
      end
      ra       = W'($urandom);
      rb       = W'($urandom);
      exp_d    = ra - rb;
      exp_b    = (ra < rb);
      check("rnd_ready", {31'd0, in_ready}, 32'd1);
      in_a     = ra;
      in_b     = rb;
      in_valid = 1'b1;
      tick();
      check("rnd_busy", {31'd0, busy}, 32'd1);
      cyc   = 0;
      first = 1'b1;
      done  = 1'b0;
      while (!done && cyc < 100) begin
        if (out_valid === 1'b1) begin
          if (first) begin
            check("rnd_lat", cyc, W);
            first = 1'b0;
          end
          check("rnd_diff", {24'd0, out_diff}, {24'd0, exp_d});
          check("rnd_borrow", {31'd0, out_borrow}, {31'd0, exp_b});
        end
        in_valid  = 1'($urandom_range(0, 1));
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        hs        = (out_valid === 1'b1) && out_ready;
        tick();
        cyc++;
        if (hs) done = 1'b1;
      end
      in_valid = 1'b0;
      if (done) n_exp++;
      check("rnd_done", {31'd0, done}, 32'd1);
      total++;
      assert (cyc + 1 >= W + 2) else begin
        bad++;
        $error("FAIL rnd_occupancy observed=%0d expected>=%0d", cyc + 1, W + 2);
      end
      check("rnd_idle", {31'd0, in_ready}, 32'd1);
    end

    out_ready = 1'b1;
    tick();
    check("hs_count", n_hs, n_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
